// File: rtl/maze_tx.sv
// maze_tx: transmit end of the SCLK/SDATA/SENABLE maze-update link, one framed word per handshake.
// Optional build macro MAZE_TX_CHECK_EN: drop out-of-range words (y > 4 or cell type 3'b111) and pulse DROP.
module maze_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8,
    parameter int WORD_W     = 16
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [WORD_W-1:0] DATA_IN,
    input  logic              VALID,
    output logic              READY,
    output logic              SCLK,
    output logic              SDATA,
    output logic              SENABLE,
    output logic              BUSY,
    output logic              DONE
`ifdef MAZE_TX_CHECK_EN
    ,
    output logic              DROP
`endif
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              ready_q, ready_d;
    logic              sclk_q, sclk_d;
    logic              sdata_q, sdata_d;
    logic              senable_q, senable_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept_s, reject_s, load_s;

`ifdef MAZE_TX_CHECK_EN
    logic              drop_q, drop_d;

    function automatic logic word_rejected(input logic [2:0] y, input logic [2:0] cell);
        return (y > 3'd4) || (cell == 3'b111);
    endfunction
`endif

    // Handshake decode: a rejected word still completes the handshake but never starts a frame.
    always_comb begin
        accept_s = VALID && ready_q && (state_q == ST_IDLE);
`ifdef MAZE_TX_CHECK_EN
        reject_s = accept_s && word_rejected(DATA_IN[13:11], DATA_IN[10:8]);
        drop_d   = reject_s;
`else
        reject_s = 1'b0;
`endif
        load_s   = accept_s && !reject_s;
    end

    // Frame sequencer: SCLK toggles every CLK_DIV cycles, SDATA moves only on falling toggles.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_d     = bit_q;
        div_d     = div_q;
        gap_d     = gap_q;
        ready_d   = ready_q;
        sclk_d    = sclk_q;
        sdata_d   = sdata_q;
        senable_d = senable_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_s) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = DATA_IN;
                    sdata_d   = DATA_IN[WORD_W-1];
                    bit_d     = '0;
                    div_d     = '0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    senable_d = 1'b1;
                    sclk_d    = 1'b0;
                end else begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d   = ST_GAP;
                            senable_d = 1'b0;
                            sdata_d   = 1'b0;
                            done_d    = 1'b1;
                            bit_d     = '0;
                            gap_d     = '0;
                        end else begin
                            // Rotating keeps the next bit at the top of the register.
                            bit_d   = bit_q + BIT_W'(1);
                            shreg_d = {shreg_q[WORD_W-2:0], shreg_q[WORD_W-1]};
                            sdata_d = shreg_q[WORD_W-2];
                        end
                    end else begin
                        sclk_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                ready_d   = 1'b1;
                busy_d    = 1'b0;
                sclk_d    = 1'b0;
                sdata_d   = 1'b0;
                senable_d = 1'b0;
            end
        endcase
    end

    // State and output registers; RESET aborts any frame without a DONE pulse.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            gap_q     <= '0;
            ready_q   <= 1'b1;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            senable_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MAZE_TX_CHECK_EN
            drop_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            gap_q     <= gap_d;
            ready_q   <= ready_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            senable_q <= senable_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MAZE_TX_CHECK_EN
            drop_q    <= drop_d;
`endif
        end
    end

    assign READY   = ready_q;
    assign SCLK    = sclk_q;
    assign SDATA   = sdata_q;
    assign SENABLE = senable_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
`ifdef MAZE_TX_CHECK_EN
    assign DROP    = drop_q;
`endif

endmodule

// File: tb/tb_maze_tx.sv
// Bench for maze_tx: instance 0 uses default timing, instance 1 uses CLK_DIV=1, GAP_CYCLES=1.
module tb_maze_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst;
    logic [1:0]  valid;
    logic [15:0] din [2];
    wire  [1:0]  ready, sclk, sdata, sen, busy, done;
`ifdef MAZE_TX_CHECK_EN
    wire  [1:0]  drop;
`endif

    maze_tx u0 (
        .CLOCK(clk), .RESET(rst[0]), .DATA_IN(din[0]), .VALID(valid[0]), .READY(ready[0]),
        .SCLK(sclk[0]), .SDATA(sdata[0]), .SENABLE(sen[0]), .BUSY(busy[0]), .DONE(done[0])
`ifdef MAZE_TX_CHECK_EN
        , .DROP(drop[0])
`endif
    );

    maze_tx #(.CLK_DIV(1), .GAP_CYCLES(1), .WORD_W(16)) u1 (
        .CLOCK(clk), .RESET(rst[1]), .DATA_IN(din[1]), .VALID(valid[1]), .READY(ready[1]),
        .SCLK(sclk[1]), .SDATA(sdata[1]), .SENABLE(sen[1]), .BUSY(busy[1]), .DONE(done[1])
`ifdef MAZE_TX_CHECK_EN
        , .DROP(drop[1])
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];
    logic [15:0] bits [2];
    int nbits [2], t_acc [2], t_prev [2], n_acc [2], n_frames [2], n_done [2];
    int n_abort [2], handled [2];
    logic [1:0] p_sclk = 2'b00, p_sdata = 2'b00, p_sen = 2'b00;

    function automatic int div_of(input int g);
        return (g == 0) ? 4 : 1;
    endfunction

    function automatic logic dropped(input logic [15:0] w);
`ifdef MAZE_TX_CHECK_EN
        return (w[13:11] > 3'd4) || (w[10:8] == 3'b111);
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle: note pending accepts, pass the rising edge, then observe both links at the falling edge.
    task automatic tick();
        logic [1:0]  acc;
        logic [15:0] ws [2];
        logic [15:0] w;
        bit          has;
        int          e;
        for (int g = 0; g < 2; g++) begin
            acc[g] = (valid[g] === 1'b1) && (ready[g] === 1'b1) && (rst[g] === 1'b0);
            ws[g]  = din[g];
        end
        @(negedge clk);
        cyc++;
        e = cyc + 1;
        for (int g = 0; g < 2; g++) begin
            if (acc[g] && !dropped(ws[g])) begin
                if (g == 0) exp_q0.push_back(ws[g]);
                else        exp_q1.push_back(ws[g]);
                t_prev[g] = t_acc[g];
                t_acc[g]  = cyc;
                n_acc[g]++;
            end
            if (sen[g] === 1'b1 && !p_sen[g]) begin
                total++;
                if (e != t_acc[g] + 1) begin
                    bad++;
                    $display("FAIL sen_rise[%0d]: edge T+%0d, want T+1", g, e - t_acc[g]);
                end
                nbits[g] = 0;
                bits[g]  = 16'h0000;
            end
            if (sclk[g] === 1'b1 && !p_sclk[g]) begin
                bits[g] = {bits[g][14:0], sdata[g]};
                nbits[g]++;
            end
            if (sclk[g] === 1'b1) begin
                total++;
                if (sen[g] !== 1'b1 || (p_sclk[g] && sdata[g] !== p_sdata[g])) begin
                    bad++;
                    $display("FAIL sclk_proto[%0d]: SENABLE=%b SDATA=%b prev SDATA=%b, want SENABLE=1 and SDATA stable", g, sen[g], sdata[g], p_sdata[g]);
                end
            end
            if (sen[g] !== 1'b1 && p_sen[g]) begin
                has = 1'b0;
                w   = 16'h0000;
                if (g == 0) begin has = exp_q0.size() > 0; if (has) w = exp_q0.pop_front(); end
                else        begin has = exp_q1.size() > 0; if (has) w = exp_q1.pop_front(); end
                if (n_abort[g] > handled[g]) begin
                    handled[g]++;
                    total++;
                    if (done[g] !== 1'b0) begin
                        bad++;
                        $display("FAIL abort_done[%0d]: DONE=%b, want 0", g, done[g]);
                    end
                end else begin
                    n_frames[g]++;
                    total++;
                    if (nbits[g] != 16) begin
                        bad++;
                        $display("FAIL rise_count[%0d]: %0d rising edges, want 16", g, nbits[g]);
                    end
                    total++;
                    if (!has || bits[g] !== w) begin
                        bad++;
                        $display("FAIL frame_bits[%0d]: got %h, want %h (queued=%0d)", g, bits[g], w, has);
                    end
                    total++;
                    if (done[g] !== 1'b1) begin
                        bad++;
                        $display("FAIL done_pulse[%0d]: DONE=%b at SENABLE fall, want 1", g, done[g]);
                    end
                    total++;
                    if (e != t_acc[g] + 1 + 32 * div_of(g)) begin
                        bad++;
                        $display("FAIL sen_fall[%0d]: edge T+%0d, want T+%0d", g, e - t_acc[g], 1 + 32 * div_of(g));
                    end
                end
            end else if (done[g] === 1'b1) begin
                total++;
                bad++;
                $display("FAIL stray_done[%0d]: DONE=1 without SENABLE fall, want 0", g);
            end
            if (done[g] === 1'b1) n_done[g]++;
            p_sclk[g]  = (sclk[g] === 1'b1);
            p_sdata[g] = (sdata[g] === 1'b1);
            p_sen[g]   = (sen[g] === 1'b1);
        end
    endtask

    task automatic send(input int g, input logic [15:0] w, input bit hold);
        int i;
        i = 0;
        while (ready[g] !== 1'b1 && i < 400) begin
            tick();
            i++;
        end
        total++;
        if (ready[g] !== 1'b1) begin
            bad++;
            $display("FAIL send_ready[%0d]: READY=%b after %0d cycles, want 1", g, ready[g], i);
        end
        valid[g] = 1'b1;
        din[g]   = w;
        tick();
        if (!hold) valid[g] = 1'b0;
    endtask

    task automatic wait_ready(input int g, input int budget, output int e_seen);
        int i;
        i = 0;
        while (ready[g] !== 1'b1 && i < budget) begin
            tick();
            i++;
        end
        e_seen = cyc + 1;
        if (ready[g] !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout[%0d]: READY=%b after %0d cycles, want 1", g, ready[g], budget);
        end
    endtask

    task automatic test_reset();
        rst   = 2'b11;
        valid = 2'b00;
        din[0] = 16'h0000;
        din[1] = 16'h0000;
        repeat (3) tick();
        for (int g = 0; g < 2; g++) begin
            total++;
            if ({ready[g], sclk[g], sdata[g], sen[g], busy[g], done[g]} !== 6'b100000) begin
                bad++;
                $display("FAIL reset_state[%0d]: RDY/SCLK/SDATA/SEN/BUSY/DONE=%b, want 100000", g,
                         {ready[g], sclk[g], sdata[g], sen[g], busy[g], done[g]});
            end
        end
        rst = 2'b00;
        tick();
    endtask

    task automatic test_single_frame();
        int f0, d0, ta, er;
        f0 = n_frames[0];
        d0 = n_done[0];
        send(0, 16'hA5C3, 1'b0);
        ta = t_acc[0];
        total++;
        if (ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL busy_start: READY=%b BUSY=%b at T+1, want 0 1", ready[0], busy[0]);
        end
        wait_ready(0, 300, er);
        total++;
        if (er != ta + 137 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL ready_return: READY at T+%0d BUSY=%b, want T+137 and 0", er - ta, busy[0]);
        end
        total++;
        if (n_frames[0] != f0 + 1 || n_done[0] != d0 + 1) begin
            bad++;
            $display("FAIL single_counts: frames=%0d dones=%0d, want 1 1", n_frames[0] - f0, n_done[0] - d0);
        end
    endtask

    task automatic test_back_to_back();
        int a0, f0, d0, er, i;
        a0 = n_acc[1];
        f0 = n_frames[1];
        d0 = n_done[1];
        send(1, 16'h0001, 1'b1);
        din[1] = 16'h8000;
        i = 0;
        while (n_acc[1] < a0 + 2 && i < 100) begin
            tick();
            i++;
        end
        valid[1] = 1'b0;
        total++;
        if (n_acc[1] != a0 + 2 || t_acc[1] - t_prev[1] != 34) begin
            bad++;
            $display("FAIL b2b_spacing: accepts=%0d spacing=%0d, want 2 and 34", n_acc[1] - a0, t_acc[1] - t_prev[1]);
        end
        wait_ready(1, 100, er);
        total++;
        if (n_frames[1] != f0 + 2 || n_done[1] != d0 + 2) begin
            bad++;
            $display("FAIL b2b_counts: frames=%0d dones=%0d, want 2 2", n_frames[1] - f0, n_done[1] - d0);
        end
    endtask

    task automatic test_busy_ignore();
        int a0, f0, er;
        a0 = n_acc[0];
        f0 = n_frames[0];
        send(0, 16'h3C5A, 1'b0);
        repeat (20) tick();
        valid[0] = 1'b1;
        din[0]   = 16'hFFFF;
        tick();
        valid[0] = 1'b0;
        din[0]   = 16'h0000;
        wait_ready(0, 300, er);
        repeat (3) tick();
        total++;
        if (n_acc[0] != a0 + 1 || n_frames[0] != f0 + 1 || sen[0] !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore: accepts=%0d frames=%0d SEN=%b, want 1 1 0", n_acc[0] - a0, n_frames[0] - f0, sen[0]);
        end
    endtask

    task automatic test_reset_abort();
        int f0, d0, er, i;
        f0 = n_frames[0];
        d0 = n_done[0];
        send(0, 16'h5A5A, 1'b0);
        i = 0;
        while (nbits[0] < 7 && i < 200) begin
            tick();
            i++;
        end
        total++;
        if (nbits[0] != 7 || sclk[0] !== 1'b1) begin
            bad++;
            $display("FAIL abort_setup: rising edges=%0d SCLK=%b, want 7 1", nbits[0], sclk[0]);
        end
        n_abort[0]++;
        rst[0] = 1'b1;
        tick();
        total++;
        if ({ready[0], sclk[0], sdata[0], sen[0], busy[0], done[0]} !== 6'b100000) begin
            bad++;
            $display("FAIL abort_state: RDY/SCLK/SDATA/SEN/BUSY/DONE=%b, want 100000",
                     {ready[0], sclk[0], sdata[0], sen[0], busy[0], done[0]});
        end
        rst[0] = 1'b0;
        tick();
        send(0, 16'h1234, 1'b0);
        wait_ready(0, 300, er);
        total++;
        if (n_frames[0] != f0 + 1 || n_done[0] != d0 + 1) begin
            bad++;
            $display("FAIL abort_follow: frames=%0d dones=%0d, want 1 1", n_frames[0] - f0, n_done[0] - d0);
        end
    endtask

`ifdef MAZE_TX_CHECK_EN
    task automatic test_drop();
        logic [15:0] words [2];
        int f0, er;
        words[0] = 16'b10_101_000_0000_0000;
        words[1] = 16'b01_010_111_0000_0000;
        for (int k = 0; k < 2; k++) begin
            f0 = n_frames[0];
            send(0, words[k], 1'b0);
            total++;
            if (drop[0] !== 1'b1 || ready[0] !== 1'b1 || sen[0] !== 1'b0) begin
                bad++;
                $display("FAIL drop_pulse[%0d]: DROP=%b READY=%b SEN=%b, want 1 1 0", k, drop[0], ready[0], sen[0]);
            end
            tick();
            total++;
            if (drop[0] !== 1'b0) begin
                bad++;
                $display("FAIL drop_width[%0d]: DROP=%b, want 0", k, drop[0]);
            end
            repeat (5) tick();
            total++;
            if (n_frames[0] != f0 || sen[0] !== 1'b0) begin
                bad++;
                $display("FAIL drop_noframe[%0d]: frames=%0d SEN=%b, want 0 0", k, n_frames[0] - f0, sen[0]);
            end
        end
        f0 = n_frames[0];
        send(0, 16'b01_010_011_1010_0000, 1'b0);
        total++;
        if (drop[0] !== 1'b0 || sen[0] !== 1'b1) begin
            bad++;
            $display("FAIL drop_pass: DROP=%b SEN=%b, want 0 1", drop[0], sen[0]);
        end
        wait_ready(0, 300, er);
        total++;
        if (n_frames[0] != f0 + 1) begin
            bad++;
            $display("FAIL drop_pass_frame: frames=%0d, want 1", n_frames[0] - f0);
        end
    endtask
`endif

    initial begin
        for (int g = 0; g < 2; g++) begin
            bits[g] = 16'h0000; nbits[g] = 0; t_acc[g] = 0; t_prev[g] = 0; n_acc[g] = 0;
            n_frames[g] = 0; n_done[g] = 0; n_abort[g] = 0; handled[g] = 0;
        end
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
`ifdef MAZE_TX_CHECK_EN
        test_drop();
`endif
        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/maze_tx.md
Name: maze_tx

Overview:
- Transmit end of the three-wire maze-update link (serial clock, data, enable) whose receive end feeds the 16-bit update word into the VGA maze display.
- Accepts one 16-bit update word per valid/ready handshake and serializes it MSB first as a single framed burst.
- Used on the robot-side FPGA to drive the link, and on the display board as a loopback/stimulus source.
- Word layout, fixed:
  - [15:14] x
  - [13:11] y
  - [10:8] cell type
  - [7:4] wall flags
  - [3:0] reserved, sent as given

Parameters:
- CLK_DIV, 4, CLOCK cycles per half period of SCLK (minimum 1).
- GAP_CYCLES, 8, idle CLOCK cycles with SENABLE low between frames (minimum 1).
- WORD_W, 16, bits per frame; the receive end requires 16.

Ports:
- CLOCK  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- DATA_IN  in  WORD_W  word to send; sampled only on an accept cycle.
- VALID  in  1  DATA_IN is valid.
- READY  out  1  block can accept a word.
- SCLK  out  1  serial clock; idles low; receiver samples SDATA on its rising edge.
- SDATA  out  1  serial data, MSB first; changes only while SCLK is low.
- SENABLE  out  1  high for the whole frame.
- BUSY  out  1  high from the cycle after accept until READY returns.
- DONE  out  1  one-cycle pulse in the cycle SENABLE falls.

Behaviour:
- Reset values: READY=1, SCLK=0, SDATA=0, SENABLE=0, BUSY=0, DONE=0.
  - Also cleared: shift register, bit counter, divider counter, gap counter; state=IDLE.
- RESET mid-frame aborts the frame. Outputs take their reset values on the next edge, with no DONE pulse.
- All outputs are registered.
- States: IDLE -> SHIFT -> GAP -> IDLE.
- IDLE:
  - READY=1.
  - Accept cycle T = rising edge where VALID && READY && !RESET.
  - On accept, latch DATA_IN into the shift register and go to SHIFT.
  - VALID without READY is ignored; DATA_IN is not sampled outside the accept cycle.
- SHIFT, cycle-level, with D=CLK_DIV:
  - Edge T+1: READY=0, BUSY=1, SENABLE=1, SDATA=word[15], SCLK=0.
  - SCLK toggles every D cycles.
    - Rising edge k (k=0..15) at T+1+D*(2k+1).
    - Falling edge k at T+1+D*(2k+2).
  - On falling edges 0..14, SDATA advances to the next lower bit.
  - On falling edge 15 (T+1+32D):
    - SENABLE=0, SDATA=0, DONE=1 for one cycle.
    - Go to GAP.
  - The bit counter runs 0..15 and is 4 bits for WORD_W=16; no wrap beyond 15.
  - The divider counter runs 0..D-1.
- GAP:
  - Outputs held idle for GAP_CYCLES cycles.
  - READY=1 and BUSY=0 at edge T+1+32D+GAP_CYCLES; state=IDLE.
- Defaults: SENABLE high for 128 cycles, T+1..T+128; READY back at T+137.
- Back-to-back: VALID held high re-accepts on the first READY cycle, giving a minimum frame spacing of 32D+GAP_CYCLES+1 cycles.
- SCLK never has an edge while SENABLE is low.

Optional Feature:
- Macro: MAZE_TX_CHECK_EN.
- Defined:
  - On an accept cycle, a word with y ([13:11]) > 4 or cell type ([10:8]) == 3'b111 is consumed but not sent.
  - The handshake still completes; a DROP output pulses for 1 cycle at T+1.
  - READY stays 1, with no frame and no DONE.
- Not defined:
  - DROP port absent.
  - Every accepted word is sent unchanged.

Test Plan:
- Reset, then send 16'hA5C3 (defaults) -> sampled bits on SCLK rising edges = 1010_0101_1100_0011. SENABLE high T+1..T+128, DONE at T+129 edge (SENABLE falls at T+1+32D = T+129), READY at T+137.
- CLK_DIV=1, GAP_CYCLES=1, VALID held high with words 16'h0001 and 16'h8000 -> two frames. Second accept exactly 34 cycles after the first; DONE pulses twice.
- VALID pulsed while BUSY with 16'hFFFF -> ignored; current frame bits unchanged, no extra frame.
- RESET asserted at rising edge 7 of a frame -> next cycle SCLK=0, SENABLE=0, SDATA=0, READY=1. No DONE; a following word 16'h1234 is sent intact.
- Protocol checks across all frames: SDATA stable while SCLK high; SCLK low whenever SENABLE low; exactly 16 rising edges per frame.
- With MAZE_TX_CHECK_EN: 16'b10_101_000_0000_0000 (y=5) -> DROP pulse, no SENABLE. 16'b01_010_111_0000_0000 -> DROP. 16'b01_010_011_1010_0000 -> normal frame.
